// File: rtl/press_classifier_if.sv
// rtl/press_classifier_if.sv - button level in, gesture ticks and busy out
//   btn_level   : debounced button level, 1 = pressed (master -> slave)
//   short_tick  : one-cycle single short press event (slave -> master)
//   long_tick   : one-cycle long press event (slave -> master)
//   repeat_tick : one-cycle auto-repeat event while long press held (slave -> master)
//   double_tick : one-cycle double click event (slave -> master)
//   busy        : classifier is inside a gesture (slave -> master)
interface press_classifier_if;
    logic btn_level;
    logic short_tick;
    logic long_tick;
    logic repeat_tick;
    logic double_tick;
    logic busy;

    modport master (
        output btn_level,
        input  short_tick,
        input  long_tick,
        input  repeat_tick,
        input  double_tick,
        input  busy
    );

    modport slave (
        input  btn_level,
        output short_tick,
        output long_tick,
        output repeat_tick,
        output double_tick,
        output busy
    );
endinterface

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced button gestures into event ticks
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears state, counter and ticks
//   bus   : press_classifier_if.slave (btn_level in; ticks and busy out)
module press_classifier #(
    parameter int unsigned LONG_CYCLES   = 25_000_000,
    parameter int unsigned GAP_CYCLES    = 12_500_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int          CW            = 25
) (
    input  logic              clk,
    input  logic              reset,
    press_classifier_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRESS1    = 3'd1;
    localparam logic [2:0] S_LONG_HOLD = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_WAIT_REL  = 3'd4;

    // Terminal counts: each count path restarts at its terminal value, so cnt never wraps.
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          short_q;
    logic          long_q;
    logic          repeat_q;
    logic          double_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
        end else begin
            // Ticks are single-cycle pulses; only the decision edge raises one.
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.btn_level) begin
                        state <= S_PRESS1;
                        cnt   <= '0;
                    end
                end
                S_PRESS1: begin
                    // Release wins over reaching the long threshold on the same edge.
                    if (!bus.btn_level) begin
                        state <= S_GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        long_q <= 1'b1;
                        state  <= S_LONG_HOLD;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LONG_HOLD: begin
                    if (!bus.btn_level) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    // A re-press wins over the gap timeout on the same edge.
                    if (bus.btn_level) begin
                        double_q <= 1'b1;
                        state    <= S_WAIT_REL;
                        cnt      <= '0;
                    end else if (cnt == GAP_LAST) begin
                        short_q <= 1'b1;
                        state   <= S_IDLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    // Second press is never timed: no long or repeat from here.
                    if (!bus.btn_level) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.short_tick  = short_q;
    assign bus.long_tick   = long_q;
    assign bus.repeat_tick = repeat_q;
    assign bus.double_tick = double_q;
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - self-checking bench for press_classifier
module tb_press_classifier;

    localparam int LONG   = 8;
    localparam int GAP    = 4;
    localparam int REPEAT = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    press_classifier_if bus ();

    press_classifier #(
        .LONG_CYCLES   (LONG),
        .GAP_CYCLES    (GAP),
        .REPEAT_CYCLES (REPEAT),
        .CW            (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick vector order: {short, long, repeat, double}
    function automatic logic [3:0] ticks();
        return {bus.short_tick, bus.long_tick, bus.repeat_tick, bus.double_tick};
    endfunction

    // Drive btn for one edge and sample 1 time unit after that edge.
    task automatic drive(input logic b);
        @(negedge clk);
        bus.btn_level = b;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 10; i++) drive(1'b0);
    endtask

    task automatic test_reset();
        flush();
        for (int i = 0; i < 3; i++) drive(1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ticks() !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async ticks=%b busy=%b exp ticks=0000 busy=0", ticks(), bus.busy);
        end
        bus.btn_level = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0);
            checks++;
            if (ticks() !== 4'b0000 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold ticks=%b busy=%b exp ticks=0000 busy=0", ticks(), bus.busy);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0);
            checks++;
            if (ticks() !== 4'b0000 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_after k=%0d ticks=%b busy=%b exp ticks=0000 busy=0", k, ticks(), bus.busy);
            end
        end
    endtask

    task automatic test_short();
        logic [3:0] exp_t;
        flush();
        for (int k = 0; k < 12; k++) begin
            drive(k <= 2);
            exp_t = (k == 7) ? 4'b1000 : 4'b0000;
            checks++;
            if (ticks() !== exp_t) begin
                errors++;
                $display("FAIL short_ticks k=%0d got=%b exp=%b", k, ticks(), exp_t);
            end
            checks++;
            if (bus.busy !== (k < 7)) begin
                errors++;
                $display("FAIL short_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 7));
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [3:0] exp_t;
        flush();
        for (int k = 0; k < 22; k++) begin
            drive(k <= 16);
            exp_t = (k == 8) ? 4'b0100 : (k == 11 || k == 14) ? 4'b0010 : 4'b0000;
            checks++;
            if (ticks() !== exp_t) begin
                errors++;
                $display("FAIL long_ticks k=%0d got=%b exp=%b", k, ticks(), exp_t);
            end
            checks++;
            if (bus.busy !== (k < 17)) begin
                errors++;
                $display("FAIL long_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 17));
            end
        end
    endtask

    task automatic test_long_boundary();
        logic [3:0] exp_t;
        flush();
        for (int k = 0; k < 16; k++) begin
            drive(k <= 7);
            exp_t = (k == 12) ? 4'b1000 : 4'b0000;
            checks++;
            if (ticks() !== exp_t) begin
                errors++;
                $display("FAIL boundary_ticks k=%0d got=%b exp=%b", k, ticks(), exp_t);
            end
            checks++;
            if (bus.busy !== (k < 12)) begin
                errors++;
                $display("FAIL boundary_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 12));
            end
        end
    endtask

    task automatic test_double();
        logic [3:0] exp_t;
        flush();
        for (int k = 0; k < 26; k++) begin
            drive(k <= 1 || (k >= 5 && k <= 20));
            exp_t = (k == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (ticks() !== exp_t) begin
                errors++;
                $display("FAIL double_ticks k=%0d got=%b exp=%b", k, ticks(), exp_t);
            end
            checks++;
            if (bus.busy !== (k < 21)) begin
                errors++;
                $display("FAIL double_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 21));
            end
        end
    endtask

    task automatic test_gap_boundary();
        logic [3:0] exp_t;
        flush();
        for (int k = 0; k < 14; k++) begin
            drive(k <= 1 || (k >= 6 && k <= 8));
            exp_t = (k == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (ticks() !== exp_t) begin
                errors++;
                $display("FAIL gapbound_ticks k=%0d got=%b exp=%b", k, ticks(), exp_t);
            end
            checks++;
            if (bus.busy !== (k < 9)) begin
                errors++;
                $display("FAIL gapbound_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 9));
            end
        end
    endtask

    // Random run-length stimulus checked against a timestamp-based gesture model:
    // ticks are predicted from elapsed edges since press, release and long events.
    task automatic test_random();
        int         g;       // 0 none, 1 first press, 2 long held, 3 released gap, 4 second press
        int         t_press;
        int         t_rel;
        int         t_long;
        int         run_left;
        logic       lvl;
        logic       do_rst;
        logic [3:0] exp_t;
        flush();
        g        = 0;
        t_press  = 0;
        t_rel    = 0;
        t_long   = 0;
        lvl      = 1'b0;
        run_left = 0;
        for (int k = 0; k < 1500; k++) begin
            if (run_left == 0) begin
                lvl      = ~lvl;
                run_left = $urandom_range(1, 13);
            end
            run_left--;
            do_rst = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            bus.btn_level = lvl;
            if (do_rst) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
                g = 0;
            end
            @(posedge clk);
            #1;
            exp_t = 4'b0000;
            case (g)
                0: if (lvl) begin g = 1; t_press = k; end
                1: if (!lvl) begin g = 3; t_rel = k; end
                   else if (k - t_press == LONG) begin exp_t = 4'b0100; g = 2; t_long = k; end
                2: if (!lvl) g = 0;
                   else if ((k - t_long) % REPEAT == 0) exp_t = 4'b0010;
                3: if (lvl) begin exp_t = 4'b0001; g = 4; end
                   else if (k - t_rel == GAP) begin exp_t = 4'b1000; g = 0; end
                default: if (!lvl) g = 0;
            endcase
            checks++;
            if (ticks() !== exp_t) begin
                errors++;
                $display("FAIL random_ticks k=%0d got=%b exp=%b", k, ticks(), exp_t);
            end
            checks++;
            if (bus.busy !== (g != 0)) begin
                errors++;
                $display("FAIL random_busy k=%0d got=%b exp=%b", k, bus.busy, (g != 0));
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.btn_level = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ticks() !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL power_on_reset ticks=%b busy=%b exp ticks=0000 busy=0", ticks(), bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_short();
        test_long_repeat();
        test_long_boundary();
        test_double();
        test_gap_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
